rr_arb: RTL
===========

RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001 Parameter W: default 4; number of requesters, W >= 2.
REQ-002 Parameter W_ENC: default $clog2(W); width of encoded grant index; not overridden by instantiators.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst_n  input  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
REQ-005 i_req  input  W  per-requester request vector; bit i high = requester i has a beat to send.
REQ-006 i_last  input  1  qualifies the granted beat; high = final beat of the granted requester's packet.
REQ-007 i_ack  input  1  downstream accepts the current beat when high with o_gnt_vld.
REQ-008 o_gnt  output  W  one-hot grant vector, or all-zero when nothing granted.
REQ-009 o_gnt_vld  output  1  high when o_gnt is non-zero.
REQ-010 o_gnt_enc  output  W_ENC  binary index of the set bit of o_gnt; 0 when o_gnt_vld low.

Function
REQ-011 State: 2-state FSM {ARB, LOCK} plus last-granted pointer ptr (W-bit one-hot register).
REQ-012 Priority mask = bits strictly toward MSB of ptr (leftward, non-inclusive unary mask of ptr).
REQ-013 In ARB: if (i_req & mask) != 0, grant lowest set bit of (i_req & mask); else grant lowest set bit of i_req; else no grant.
REQ-014 In LOCK: o_gnt = locked-requester register lk & i_req; no other requester granted regardless of priority.
REQ-015 o_gnt, o_gnt_vld, o_gnt_enc are combinational from state, ptr, lk and i_req; zero cycles of latency from request to grant.
REQ-016 Beat accepted when o_gnt_vld & i_ack; no state change on cycles without acceptance.
REQ-017 ARB, accepted, i_last=1: ptr <= o_gnt; remain ARB.
REQ-018 ARB, accepted, i_last=0: lk <= o_gnt; go LOCK; ptr unchanged.
REQ-019 LOCK, accepted, i_last=1: ptr <= lk; go ARB.
REQ-020 LOCK, accepted, i_last=0: remain LOCK.
REQ-021 LOCK, locked requester drops i_req: o_gnt_vld=0, FSM stays LOCK until that requester reasserts and completes with i_last=1.
REQ-022 i_ack with o_gnt_vld=0: ignored; i_last ignored when no beat accepted.
REQ-023 Requests changing while not accepted (ARB) re-arbitrate combinationally each cycle; a grant is not held across non-accepted cycles in ARB.
REQ-024 Single requester asserting continuously with i_last=1 every beat: granted every cycle (no bubble).
REQ-025 All W requesters asserting continuously, single-beat packets, i_ack=1: grants rotate 0,1,...,W-1,0 with no requester starved longer than W-1 accepted beats.
REQ-026 Wrap-around: ptr at bit W-1 gives empty mask; selection falls back to lowest set bit of i_req.
REQ-027 o_gnt has at most one bit set in every cycle, in both states.

Reset
REQ-028 On arst_n low, asynchronously: FSM = ARB, ptr = one-hot bit W-1, lk = 0.
REQ-029 Consequence: first arbitration after reset gives requester 0 highest priority.
REQ-030 With i_req=0 during/after reset: o_gnt=0, o_gnt_vld=0, o_gnt_enc=0.
REQ-031 Reset asserted mid-packet (LOCK): lock discarded, ARB on release; the interrupted packet receives no further priority.

Verification
REQ-032 W=4, after reset, i_req=4'b1111, i_ack=1, i_last=1 for 8 cycles -> o_gnt_enc sequence 0,1,2,3,0,1,2,3.
REQ-033 ptr at bit 2, i_req=4'b0011 -> o_gnt=4'b0001 (wrap); then ptr=bit 0, i_req=4'b0011 -> o_gnt=4'b0010.
REQ-034 i_req=4'b0110, accept req1 with i_last=0, then i_req=4'b1111 for 3 cycles with i_last=0,0,1 -> o_gnt=4'b0010 all 3 cycles; next cycle o_gnt=4'b0100.
REQ-035 In LOCK on req2, drop i_req[2] for 2 cycles with i_req=4'b1011 -> o_gnt_vld=0 both cycles; reassert -> o_gnt=4'b0100.
REQ-036 i_req=4'b1000, i_ack=0 for 5 cycles -> o_gnt=4'b1000 held, ptr unchanged; then i_req=4'b1001 -> o_gnt=4'b0001.
REQ-037 Assert arst_n low in LOCK on req3 with i_req=4'b1111 -> after release o_gnt=4'b0001, FSM ARB.

Source files
------------

// File: rtl/rr_arb.sv
// Round-robin arbiter with packet lock: grants one requester per cycle and holds
// the grant on a multi-beat packet until its final beat is accepted.
//
// state | meaning
// ARB   | free arbitration; priority starts just above the last-granted requester
// LOCK  | mid-packet; only the locked requester may be granted
module rr_arb #(
   parameter int W     = 4,
   parameter int W_ENC = $clog2(W)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [W-1:0]     i_req,
   input  logic             i_last,
   input  logic             i_ack,
   output logic [W-1:0]     o_gnt,
   output logic             o_gnt_vld,
   output logic [W_ENC-1:0] o_gnt_enc
);

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   localparam logic [W-1:0] ONE      = W'(1);
   localparam logic [W-1:0] PTR_RST  = ONE << (W - 1);

   state_t       state_q, state_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] lk_q, lk_d;
   logic [W-1:0] mask;
   logic [W-1:0] req_hi;
   logic [W-1:0] pick_src;
   logic [W-1:0] gnt;
   logic         accept;

   // Mask keeps only bits strictly above the one-hot pointer; lowest-set-bit
   // isolation is x & -x.
   always_comb begin
      mask     = ~(ptr_q | (ptr_q - ONE));
      req_hi   = i_req & mask;
      pick_src = (req_hi != '0) ? req_hi : i_req;
      gnt      = '0;
      if (state_q == ST_LOCK) begin
         gnt = lk_q & i_req;
      end else begin
         gnt = pick_src & (~pick_src + ONE);
      end
   end

   always_comb begin
      o_gnt     = gnt;
      o_gnt_vld = (gnt != '0);
      o_gnt_enc = '0;
      for (int i = 0; i < W; i++) begin
         if (gnt[i]) o_gnt_enc = W_ENC'(i);
      end
   end

   assign accept = o_gnt_vld & i_ack;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lk_d    = lk_q;
      if (accept) begin
         case (state_q)
            ST_ARB: begin
               if (i_last) begin
                  ptr_d = gnt;
               end else begin
                  lk_d    = gnt;
                  state_d = ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (i_last) begin
                  ptr_d   = lk_q;
                  state_d = ST_ARB;
               end
            end
            default: state_d = ST_ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_ARB;
         ptr_q   <= PTR_RST;
         lk_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lk_q    <= lk_d;
      end
   end

endmodule
